// File: rtl/alarm_trigger_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } state_e;

    localparam int RING_S_DEF     = 60;
    localparam int SNOOZE_S_DEF   = 300;
    localparam int MAX_SNOOZE_DEF = 3;

    localparam int HL_W   = 2;
    localparam int HR_W   = 4;
    localparam int ML_W   = 3;
    localparam int MR_W   = 4;
    localparam int CNT_W  = 9;
    localparam int SCNT_W = 2;

endpackage

// File: rtl/alarm_trigger_if.sv
// Time, alarm, button and alarm-status signals between the clock core and the alarm trigger.
interface alarm_trigger_if;
    import alarm_trigger_pkg::*;

    logic              tick_1hz;
    logic [HL_W-1:0]   cur_hours_left;
    logic [HR_W-1:0]   cur_hours_right;
    logic [ML_W-1:0]   cur_minutes_left;
    logic [MR_W-1:0]   cur_minutes_right;
    logic [HL_W-1:0]   al_hours_left;
    logic [HR_W-1:0]   al_hours_right;
    logic [ML_W-1:0]   al_minutes_left;
    logic [MR_W-1:0]   al_minutes_right;
    logic              alarm_on;
    logic              set_alarm_en;
    logic              stop_button;
    logic              snooze_button;
    logic              buzzer;
    logic              ringing;
    logic              snoozed;
    logic [SCNT_W-1:0] snooze_cnt;

    modport master (
        output tick_1hz, cur_hours_left, cur_hours_right, cur_minutes_left, cur_minutes_right,
               al_hours_left, al_hours_right, al_minutes_left, al_minutes_right,
               alarm_on, set_alarm_en, stop_button, snooze_button,
        input  buzzer, ringing, snoozed, snooze_cnt
    );

    modport slave (
        input  tick_1hz, cur_hours_left, cur_hours_right, cur_minutes_left, cur_minutes_right,
               al_hours_left, al_hours_right, al_minutes_left, al_minutes_right,
               alarm_on, set_alarm_en, stop_button, snooze_button,
        output buzzer, ringing, snoozed, snooze_cnt
    );

endinterface

// File: rtl/alarm_trigger_countdown.sv
// Seconds down-counter: loads on request, decrements on tick, floors at 1; done = last tick.
module alarm_countdown
    import alarm_trigger_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && tick_i && (cnt_q > 9'd1)) begin
            cnt_d = cnt_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 9'd1) && tick_i;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm match detection, ring/snooze state machine and registered buzzer drive.
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter int RING_S     = RING_S_DEF,
    parameter int SNOOZE_S   = SNOOZE_S_DEF,
    parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    alarm_trigger_if.slave bus
);

    localparam logic [CNT_W-1:0]  RING_LOAD   = CNT_W'(RING_S);
    localparam logic [CNT_W-1:0]  SNOOZE_LOAD = CNT_W'(SNOOZE_S);
    localparam logic [SCNT_W:0]   MAX_SN      = (SCNT_W+1)'(MAX_SNOOZE);

    state_e            state_q, state_d;
    logic [SCNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic              beep_q, beep_d;
    logic              match_q;
    logic              armed_q;
    logic              buzzer_q;
    logic              match, trigger;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              done;

    assign match = (bus.cur_hours_left    == bus.al_hours_left)
                && (bus.cur_hours_right   == bus.al_hours_right)
                && (bus.cur_minutes_left  == bus.al_minutes_left)
                && (bus.cur_minutes_right == bus.al_minutes_right)
                && bus.alarm_on && !bus.set_alarm_en;

    // armed_q masks the first clock after reset so a match already present at release does not ring
    assign trigger = match && !match_q && armed_q;

    alarm_countdown u_countdown (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(load_val),
        .tick_i    (bus.tick_1hz),
        .en_i      (state_q != IDLE),
        .done_o    (done)
    );

    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_d       = beep_q;
        load         = 1'b0;
        load_val     = RING_LOAD;
        if (!bus.alarm_on) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_d      = RING;
                        load         = 1'b1;
                        snooze_cnt_d = '0;
                        beep_d       = 1'b1;
                    end
                end
                RING: begin
                    if (bus.stop_button) begin
                        state_d = IDLE;
                    end else if (bus.snooze_button) begin
                        if ({1'b0, snooze_cnt_q} < MAX_SN) begin
                            state_d      = SNOOZE;
                            load         = 1'b1;
                            load_val     = SNOOZE_LOAD;
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (done) begin
                        state_d = IDLE;
                    end else if (bus.tick_1hz) begin
                        beep_d = !beep_q;
                    end
                end
                SNOOZE: begin
                    if (bus.stop_button) begin
                        state_d = IDLE;
                    end else if (done) begin
                        state_d = RING;
                        load    = 1'b1;
                        beep_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b0;
            match_q      <= 1'b0;
            armed_q      <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            snooze_cnt_q <= snooze_cnt_d;
            beep_q       <= beep_d;
            match_q      <= match;
            armed_q      <= 1'b1;
            buzzer_q     <= (state_q == RING) && beep_q;
        end
    end

    assign bus.ringing    = (state_q == RING);
    assign bus.snoozed    = (state_q == SNOOZE);
    assign bus.snooze_cnt = snooze_cnt_q;
    assign bus.buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: ring, timeout, snooze limit, button priority, disable and reset.
module tb_alarm_trigger;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    alarm_trigger_if bus();

    alarm_trigger dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input int hl, input int hr, input int ml, input int mr);
        bus.cur_hours_left    = 2'(hl);
        bus.cur_hours_right   = 4'(hr);
        bus.cur_minutes_left  = 3'(ml);
        bus.cur_minutes_right = 4'(mr);
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        step(1);
        bus.tick_1hz = 1'b0;
        step(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic stop, input logic snz);
        bus.stop_button   = stop;
        bus.snooze_button = snz;
        step(1);
        bus.stop_button   = 1'b0;
        bus.snooze_button = 1'b0;
    endtask

    // leave 07:30 and come back to it: a fresh minute edge; returns with RING visible
    task automatic new_event();
        set_time(0, 7, 3, 1);
        step(2);
        set_time(0, 7, 3, 0);
        step(1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        bus.tick_1hz = 1'b0;
        bus.stop_button = 1'b0;
        bus.snooze_button = 1'b0;
        bus.alarm_on = 1'b1;
        bus.set_alarm_en = 1'b0;
        bus.al_hours_left = 2'd0;
        bus.al_hours_right = 4'd7;
        bus.al_minutes_left = 3'd3;
        bus.al_minutes_right = 4'd0;
        set_time(0, 7, 2, 9);
        step(2);
        chk("rst_ringing", 32'(bus.ringing), 0);
        chk("rst_snoozed", 32'(bus.snoozed), 0);
        chk("rst_buzzer", 32'(bus.buzzer), 0);
        chk("rst_scnt", 32'(bus.snooze_cnt), 0);
        rst = 1'b1;
        step(3);
        chk("idle_no_ring", 32'(bus.ringing), 0);

        // 07:29 -> 07:30 rings one clock later, buzzer one more clock later
        set_time(0, 7, 3, 0);
        step(1);
        chk("trig_ringing", 32'(bus.ringing), 1);
        chk("trig_buzz_lag", 32'(bus.buzzer), 0);
        chk("trig_scnt", 32'(bus.snooze_cnt), 0);
        step(1);
        chk("trig_buzz_on", 32'(bus.buzzer), 1);

        // beep toggles per tick, then timeout after the 60th tick
        tick();
        chk("beep_off", 32'(bus.buzzer), 0);
        tick();
        chk("beep_on", 32'(bus.buzzer), 1);
        ticks(57);
        chk("ring_59", 32'(bus.ringing), 1);
        tick();
        chk("timeout_idle", 32'(bus.ringing), 0);
        chk("timeout_buzz", 32'(bus.buzzer), 0);
        step(10);
        chk("no_rering", 32'(bus.ringing), 0);

        // three snoozes, each expiring back into RING; fourth behaves as stop
        new_event();
        chk("ev2_ring", 32'(bus.ringing), 1);
        chk("ev2_scnt", 32'(bus.snooze_cnt), 0);
        for (int i = 1; i <= 3; i++) begin
            press(1'b0, 1'b1);
            chk("snz_state", 32'(bus.snoozed), 1);
            chk("snz_cnt", 32'(bus.snooze_cnt), 32'(i));
            if (i == 1) begin
                press(1'b0, 1'b1);
                chk("snz_ignored", 32'(bus.snoozed), 1);
                chk("snz_ign_cnt", 32'(bus.snooze_cnt), 1);
            end
            ticks(299);
            chk("snz_299", 32'(bus.snoozed), 1);
            tick();
            chk("snz_back_ring", 32'(bus.ringing), 1);
            chk("snz_back_cnt", 32'(bus.snooze_cnt), 32'(i));
        end
        press(1'b0, 1'b1);
        chk("snz4_ringing", 32'(bus.ringing), 0);
        chk("snz4_snoozed", 32'(bus.snoozed), 0);
        chk("snz4_cnt", 32'(bus.snooze_cnt), 3);

        // stop and snooze together: stop wins, count unchanged
        new_event();
        chk("ev3_cnt_clear", 32'(bus.snooze_cnt), 0);
        press(1'b0, 1'b1);
        ticks(300);
        chk("ev3_ring", 32'(bus.ringing), 1);
        press(1'b1, 1'b1);
        chk("both_idle", 32'(bus.ringing), 0);
        chk("both_snoozed", 32'(bus.snoozed), 0);
        chk("both_cnt", 32'(bus.snooze_cnt), 1);

        // new minute edge during SNOOZE is ignored; alarm_on drop forces IDLE
        new_event();
        press(1'b0, 1'b1);
        chk("ev4_snz", 32'(bus.snoozed), 1);
        set_time(0, 7, 3, 1);
        step(2);
        set_time(0, 7, 3, 0);
        step(2);
        chk("trig_in_snz", 32'(bus.snoozed), 1);
        chk("trig_in_snz_c", 32'(bus.snooze_cnt), 1);
        set_time(0, 7, 3, 1);
        bus.alarm_on = 1'b0;
        step(1);
        chk("off_snoozed", 32'(bus.snoozed), 0);
        chk("off_ringing", 32'(bus.ringing), 0);
        bus.alarm_on = 1'b1;
        bus.set_alarm_en = 1'b1;
        step(2);
        set_time(0, 7, 3, 0);
        step(3);
        chk("edit_no_trig", 32'(bus.ringing), 0);
        set_time(0, 7, 3, 1);
        bus.set_alarm_en = 1'b0;
        step(2);

        // reset mid-RING silences at once; no re-ring while 07:30 holds
        new_event();
        step(1);
        chk("ev5_buzz", 32'(bus.buzzer), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_buzz", 32'(bus.buzzer), 0);
        chk("rst_mid_ring", 32'(bus.ringing), 0);
        @(negedge clk);
        rst = 1'b1;
        step(5);
        chk("post_rst_ring", 32'(bus.ringing), 0);
        chk("post_rst_buzz", 32'(bus.buzzer), 0);
        new_event();
        chk("next_day_ring", 32'(bus.ringing), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 The block SHALL have parameter RING_S, default 60, giving the ring timeout in seconds.
REQ-002 The block SHALL have parameter SNOOZE_S, default 300, giving the snooze duration in seconds.
REQ-003 The block SHALL have parameter MAX_SNOOZE, default 3, giving the maximum number of snoozes per alarm event.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-007 cur_hours_left/right, cur_minutes_left/right  in  2/4/3/4  current time, BCD.
REQ-008 al_hours_left/right, al_minutes_left/right  in  2/4/3/4  alarm time, BCD, from the alarm-setting stage.
REQ-009 alarm_on  in  1  alarm armed.
REQ-010 set_alarm_en  in  1  alarm edit in progress.
REQ-011 stop_button, snooze_button  in  1  one-cycle pulses, already debounced.
REQ-012 buzzer  out  1  buzzer drive.
REQ-013 ringing  out  1  state is RING.
REQ-014 snoozed  out  1  state is SNOOZE.
REQ-015 snooze_cnt  out  2  snoozes used in the current event.

Function
REQ-016 match SHALL be all four current digits equal to the alarm digits, AND alarm_on=1, AND set_alarm_en=0.
REQ-017 match_r SHALL be match registered each clk.
REQ-018 trigger SHALL be match & !match_r.
  - The rising-edge requirement prevents re-ringing within the same minute after a stop.
REQ-019 The state machine SHALL have the states IDLE, RING, and SNOOZE, with 2-bit encoding.
REQ-020 IDLE and trigger -> RING on the next clk.
  - On entry: countdown=RING_S, snooze_cnt=0, beep_phase=1.
REQ-021 RING and stop_button -> IDLE.
REQ-022 RING and snooze_button and snooze_cnt<MAX_SNOOZE -> SNOOZE.
  - On entry: countdown=SNOOZE_S, snooze_cnt+1.
REQ-023 RING and snooze_button and snooze_cnt==MAX_SNOOZE SHALL behave as stop -> IDLE.
REQ-024 RING, tick_1hz, and countdown==1 -> IDLE (timeout).
  - Otherwise tick_1hz decrements countdown.
REQ-025 SNOOZE and stop_button -> IDLE.
  - snooze_button in SNOOZE SHALL be ignored.
REQ-026 SNOOZE, tick_1hz, and countdown==1 -> RING.
  - countdown=RING_S, beep_phase=1, snooze_cnt held.
REQ-027 alarm_on=0 in any state SHALL force IDLE on the next clk.
  - This has the highest priority.
REQ-028 Priority SHALL be: alarm_on=0 > stop_button > snooze_button > tick_1hz timeout.
REQ-029 Countdown arithmetic:
  - 9-bit unsigned, sized for values up to 511.
  - Never decrements below 1.
  - Only the transitions above reload it.
REQ-030 beep_phase SHALL toggle on each tick_1hz while in RING.
  - buzzer = (state==RING) & beep_phase, registered.
REQ-031 In RING, buzzer SHALL go high 1 clk after state enters RING.
REQ-032 ringing and snoozed SHALL be decoded directly from the state register, with no added latency.
REQ-033 In IDLE, snooze_cnt SHALL hold its last value until the next trigger clears it.
REQ-034 A trigger arriving while in RING or SNOOZE SHALL be ignored.

Reset
REQ-035 When rst=0, the following SHALL be cleared asynchronously:
  - state=IDLE;
  - countdown=0;
  - snooze_cnt=0;
  - beep_phase=0;
  - match_r=0;
  - buzzer=0.
REQ-036 A reset mid-RING SHALL silence buzzer immediately.
  - After release: if match is still 1, match_r loads 1 and no re-trigger occurs until the next minute match.

Structure
REQ-037 A shared package SHALL hold:
  - the state typedef (IDLE, RING, SNOOZE);
  - the default RING_S, SNOOZE_S, and MAX_SNOOZE constants;
  - the BCD digit widths.
REQ-038 Sub-module alarm_countdown SHALL contain:
  - the 9-bit load/decrement-on-tick counter;
  - a done output meaning count==1 & tick.
REQ-039 The FSM, match logic, and buzzer logic SHALL reside in alarm_trigger.

Verification
REQ-040 Alarm 07:30, alarm_on=1, time steps 07:29->07:30 -> ringing=1 one clk later, buzzer=1 the following clk, snooze_cnt=0.
REQ-041 Ringing, 60 ticks with no buttons -> IDLE after the 60th tick, buzzer=0, and no re-ring while time stays 07:30.
REQ-042 Ringing, snooze pressed 3 times (each followed by 300 ticks) -> snooze_cnt=3, each 300th tick returns to RING; the 4th snooze -> IDLE.
REQ-043 stop_button and snooze_button in the same clk during RING -> IDLE, snooze_cnt unchanged.
REQ-044 In SNOOZE, alarm_on dropped -> IDLE next clk; with set_alarm_en=1 at match time -> no trigger.
REQ-045 rst asserted mid-RING at 07:30, released while 07:30 holds -> IDLE, buzzer=0, no ring until next day's 07:30 edge.
